clk_div_meter: RTL and testbench

CLK_DIV_METER -- requirements
Module: clk_div_meter

---
 rtl/clk_div_meter.sv | 112 +++++++++++
 tb/tb_clk_div_meter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_meter.sv
// Measures the period and high time of a slow clock against clk_in, with lock and timeout flags.
// Optional duty-cycle measurement is compiled in with CLK_DIV_METER_DUTY_EN.
module clk_div_meter #(
  parameter int          CNT_W      = 16,
  parameter int          LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 2**CNT_W-1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_meas,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int              MW     = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  // The match counter counts repeats, so a run of LOCK_COUNT equal periods holds LOCK_COUNT-1.
  localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_COUNT - 1);

  typedef enum logic {S_IDLE, S_MEAS} state_t;

  state_t           r_state;
  logic             r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [MW-1:0]    r_match;
  logic             r_valid, r_locked, r_timeout;

  logic             w_edge, w_tmo_hit;
  logic [MW-1:0]    w_match_nxt;

  assign w_edge    = r_sync2 & ~r_prev;
  assign w_tmo_hit = (r_cnt == TMO);

  always_comb begin
    w_match_nxt = '0;
    if (r_cnt == r_period)
      w_match_nxt = (r_match == LOCK_M) ? r_match : r_match + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_period  <= '0;
      r_match   <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync1 <= clk_meas;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      if (w_edge) begin
        // Edge wins over a coincident timeout; the first edge only opens a period.
        r_state   <= S_MEAS;
        r_cnt     <= CNT_W'(1);
        r_timeout <= 1'b0;
        if (r_state == S_MEAS) begin
          r_period <= r_cnt;
          r_valid  <= 1'b1;
          r_match  <= w_match_nxt;
          r_locked <= (w_match_nxt == LOCK_M);
        end
      end else if (w_tmo_hit) begin
        r_state   <= S_IDLE;
        r_timeout <= 1'b1;
        r_locked  <= 1'b0;
        r_period  <= '0;
        r_match   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef CLK_DIV_METER_DUTY_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_hcnt <= '0;
      r_high <= '0;
    end else if (w_edge) begin
      r_hcnt <= CNT_W'(1);
      if (r_state == S_MEAS) r_high <= r_hcnt;
    end else if (w_tmo_hit) begin
      r_high <= '0;
    end else if (r_state == S_MEAS && r_sync2 && r_hcnt != TMO) begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign high_time = r_high;
`else
  assign high_time = '0;
`endif

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_div_meter.sv
// Self-checking bench for clk_div_meter: random waveforms scored against a period-sequence model.
`timescale 1us/1ns
module tb_clk_div_meter;

  localparam int CNT_W = 16;
  localparam int LOCK  = 4;
  localparam int TMO   = 50;
`ifdef CLK_DIV_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
    logic             lk;
    logic             to;
  } rec_t;

  typedef struct {
    int n;
    int h;
  } seg_t;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             clk_meas = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             period_valid, locked, timeout;

  int   n_checks = 0;
  int   n_fail = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  seg_t segs[$];

  clk_div_meter #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst(rst), .clk_meas(clk_meas), .period(period),
    .high_time(high_time), .period_valid(period_valid), .locked(locked), .timeout(timeout)
  );

  always #500 clk_in = ~clk_in;  // 1 kHz

  always @(negedge clk_in)
    if (period_valid === 1'b1) obs_q.push_back('{period, high_time, locked, timeout});

  // Every edge after the first closes the segment before it; locked once the
  // last LOCK closed periods of this session are all equal.
  function automatic void build_exp();
    int run = 0;
    int prev = 0;
    exp_q.delete();
    for (int i = 0; i + 1 < segs.size(); i++) begin
      run  = (segs[i].n == prev) ? run + 1 : 1;
      prev = segs[i].n;
      exp_q.push_back('{CNT_W'(segs[i].n), DUTY ? CNT_W'(segs[i].h) : '0, run >= LOCK, 1'b0});
    end
  endfunction

  task automatic wave(input int n, input int h);
    segs.push_back('{n, h});
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      clk_meas = (i < h);
    end
  endtask

  task automatic idle_low(input int k);
    repeat (k) begin
      @(negedge clk_in);
      clk_meas = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    clk_meas = 1'b0;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    obs_q.delete();
    segs.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    n_checks += 5;
    if (period !== '0)        begin n_fail++; $display("FAIL rst_period: got %0d want 0", period); end
    if (high_time !== '0)     begin n_fail++; $display("FAIL rst_high: got %0d want 0", high_time); end
    if (period_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", period_valid); end
    if (locked !== 1'b0)      begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
    if (timeout !== 1'b0)     begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    idle_low(3);
    wave(10, 5);
    n_checks += 2;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL lock_first_edge: got %0d pulses want 0", obs_q.size()); end
    if (period !== '0)      begin n_fail++; $display("FAIL lock_first_period: got %0d want 0", period); end
    repeat (6) wave(10, 5);
    idle_low(6);
    build_exp();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lock_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lock_rec[%0d]: got p=%0d h=%0d lk=%b to=%b want p=%0d h=%0d lk=%b to=%b", i,
                 obs_q[i].p, obs_q[i].h, obs_q[i].lk, obs_q[i].to, exp_q[i].p, exp_q[i].h, exp_q[i].lk, exp_q[i].to);
      end
    end
    if (obs_q.size() >= 4) begin
      n_checks += 2;
      if (obs_q[2].lk !== 1'b0) begin n_fail++; $display("FAIL lock_third: got %b want 0", obs_q[2].lk); end
      if (obs_q[3].lk !== 1'b1) begin n_fail++; $display("FAIL lock_fourth: got %b want 1", obs_q[3].lk); end
    end
  endtask

  task automatic test_div_change();
    do_reset();
    idle_low(3);
    repeat (6) wave(10, 5);
    repeat (6) wave(8, 4);
    idle_low(6);
    build_exp();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL div_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL div_rec[%0d]: got p=%0d h=%0d lk=%b want p=%0d h=%0d lk=%b", i,
                 obs_q[i].p, obs_q[i].h, obs_q[i].lk, exp_q[i].p, exp_q[i].h, exp_q[i].lk);
      end
    end
    if (obs_q.size() >= 10) begin
      n_checks += 3;
      if (obs_q[6].p !== 16'd8) begin n_fail++; $display("FAIL div_first8_p: got %0d want 8", obs_q[6].p); end
      if (obs_q[6].lk !== 1'b0) begin n_fail++; $display("FAIL div_first8_lk: got %b want 0", obs_q[6].lk); end
      if (obs_q[9].lk !== 1'b1) begin n_fail++; $display("FAIL div_relock: got %b want 1", obs_q[9].lk); end
    end
  endtask

  task automatic test_duty();
    do_reset();
    idle_low(3);
    repeat (5) wave(10, 3);
    idle_low(6);
    build_exp();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL duty_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL duty_rec[%0d]: got p=%0d h=%0d want p=%0d h=%0d", i, obs_q[i].p, obs_q[i].h, exp_q[i].p, exp_q[i].h);
      end
    end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0].h !== (DUTY ? 16'd3 : 16'd0)) begin
        n_fail++; $display("FAIL duty_high: got %0d want %0d", obs_q[0].h, DUTY ? 3 : 0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    idle_low(3);
    for (int g = 0; g < 8; g++) begin
      int n = $urandom_range(20, 5);
      int h = $urandom_range(n - 1, 1);
      int r = $urandom_range(5, 1);
      repeat (r) wave(n, h);
    end
    idle_low(6);
    build_exp();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_rec[%0d]: got p=%0d h=%0d lk=%b want p=%0d h=%0d lk=%b", i,
                 obs_q[i].p, obs_q[i].h, obs_q[i].lk, exp_q[i].p, exp_q[i].h, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_timeout();
    int first = 0;
    do_reset();
    idle_low(3);
    repeat (5) wave(10, 5);
    @(negedge clk_in);
    clk_meas = 1'b1;
    // Two synchronizer stages plus the reload cycle, then TIMEOUT counted cycles.
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_in);
      if (timeout === 1'b1 && first == 0) first = k;
      if (k == 5) clk_meas = 1'b0;
    end
    n_checks += 4;
    if (first !== TMO + 3)  begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", first, TMO + 3); end
    if (period !== '0)      begin n_fail++; $display("FAIL tmo_period: got %0d want 0", period); end
    if (high_time !== '0)   begin n_fail++; $display("FAIL tmo_high: got %0d want 0", high_time); end
    if (locked !== 1'b0)    begin n_fail++; $display("FAIL tmo_locked: got %b want 0", locked); end
    obs_q.delete();
    segs.delete();
    wave(8, 5);
    n_checks += 2;
    if (timeout !== 1'b0)   begin n_fail++; $display("FAIL tmo_clear: got %b want 0", timeout); end
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL tmo_no_valid: got %0d pulses want 0", obs_q.size()); end
    repeat (3) wave(8, 5);
    idle_low(6);
    build_exp();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL tmo_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tmo_rec[%0d]: got p=%0d h=%0d lk=%b want p=%0d h=%0d lk=%b", i,
                 obs_q[i].p, obs_q[i].h, obs_q[i].lk, exp_q[i].p, exp_q[i].h, exp_q[i].lk);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle_low(3);
    repeat (6) wave(10, 5);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      clk_meas = (i < 5);
    end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_prelock: got %b want 1", locked); end
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    obs_q.delete();
    segs.delete();
    n_checks += 2;
    if (locked !== 1'b0)  begin n_fail++; $display("FAIL mid_locked: got %b want 0", locked); end
    if (period !== '0)    begin n_fail++; $display("FAIL mid_period: got %0d want 0", period); end
    idle_low(3);
    repeat (5) wave(8, 4);
    idle_low(6);
    build_exp();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_rec[%0d]: got p=%0d h=%0d lk=%b want p=%0d h=%0d lk=%b", i,
                 obs_q[i].p, obs_q[i].h, obs_q[i].lk, exp_q[i].p, exp_q[i].h, exp_q[i].lk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_div_change();
    test_duty();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
